// File: rtl/ifu_pc.sv
// ifu_pc: program-counter stage feeding instruction memory in the single-cycle MIPS datapath.
// It holds the PC, selects the next PC (sequential, branch, jump or jump-register),
// and halts fetch on a sticky fault when a target is misaligned or out of range.
// Optional macro IFU_INSTR_COUNT_EN adds a counter of PC advances.
// Ports:
//   clk, reset (async, active-high)
//   stall      hold the PC this cycle
//   npc_op     next-PC select: 0 seq, 1 branch, 2 jump, 3 jump register, 4-7 seq
//   cmp_true   branch condition
//   imm16      signed branch offset in words
//   imm26      jump target field
//   rs_data    jump-register target
//   pc         current PC, drives the instruction-memory address
//   pc_plus8   link value
//   fault      sticky illegal-target flag
//   fault_pc   target that caused the fault
//   instr_cnt  count of PC loads; 0 when the counter is not built
module ifu_pc #(
    parameter logic [31:0] INIT_ADDR = 32'h0000_3000,
    parameter int          IM_WORDS  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic        cmp_true,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] instr_cnt
);

    // Upper bound is one past the last word; 33 bits keep it from wrapping
    // when the memory window sits at the top of the address space.
    localparam logic [32:0] LO_BOUND = {1'b0, INIT_ADDR};
    localparam logic [32:0] HI_BOUND = LO_BOUND + (33'(IM_WORDS) << 2);

    logic [31:0] seq;
    logic [31:0] br;
    logic [31:0] jmp;
    logic [31:0] target;
    logic        legal;
    logic        load;

    assign seq      = pc + 32'd4;
    assign br       = seq + {{14{imm16[15]}}, imm16, 2'b00};
    assign jmp      = {seq[31:28], imm26, 2'b00};
    assign pc_plus8 = pc + 32'd8;

    always_comb begin
        target = seq;
        case (npc_op)
            3'd1:    target = cmp_true ? br : seq;
            3'd2:    target = jmp;
            3'd3:    target = rs_data;
            default: target = seq;
        endcase
    end

    assign legal = (target[1:0] == 2'b00)
                 && ({1'b0, target} >= LO_BOUND)
                 && ({1'b0, target} < HI_BOUND);

    // A PC load happens only on a normal, legal update.
    assign load = !fault && !stall && legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= INIT_ADDR;
            fault    <= 1'b0;
            fault_pc <= 32'h0;
        end else if (!fault && !stall) begin
            if (legal) begin
                pc <= target;
            end else begin
                fault    <= 1'b1;
                fault_pc <= target;
            end
        end
    end

`ifdef IFU_INSTR_COUNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 32'h0;
        end else if (load) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign instr_cnt = cnt;
`else
    assign instr_cnt = 32'h0;
`endif

endmodule
